// File: rtl/pc_trace_capture_pkg.sv
// pc_trace_capture_pkg
//   Shared definitions for the PC trace capture block: capture FSM state
//   encoding, trace entry width and the packed entry layout {pc, data}.
package pc_trace_capture_pkg;

  localparam int unsigned ENTRY_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/pc_trace_capture_fifo.sv
// trace_fifo
//   First-word-fall-through synchronous FIFO holding trace entries.
//   Ports:
//     clk, rst       clock, synchronous active-low reset
//     push, din      write request and entry
//     pop            read request (ignored while empty)
//     dout           head entry, zero while empty
//     full, empty    occupancy flags
//     count          occupancy 0..DEPTH
//   A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo
  import pc_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         din,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_acc;
  logic               pop_acc;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);
  assign dout     = empty ? '0 : mem[rd_ptr];

  // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through dout when non-empty.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_trace_capture.sv
// pc_trace_capture
//   Observes the processor's PCValue/WriteData pair, records one entry per
//   PC change into a FWFT FIFO, flags a halted core when the PC stays put for
//   HALT_CYCLES cycles, and drains entries through a valid/ready port.
//   Ports:
//     clk, rst             clock, synchronous active-low reset
//     PCValue, WriteData   observed architectural outputs
//     capture_en           arm (1) / disarm (0) capture
//     rd_ready             consumer accepts the head entry
//     rd_valid             FIFO non-empty
//     rd_pc, rd_data       head entry fields
//     count                FIFO occupancy
//     overflow             sticky: an entry was dropped
//     drop_count           saturating count of dropped entries
//     halted               high while the capture FSM is STOPPED
module pc_trace_capture
  import pc_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 8,
  parameter int unsigned DROP_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            PCValue,
  input  logic [31:0]            WriteData,
  input  logic                   capture_en,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   halted
);

  localparam int unsigned SW = $clog2(HALT_CYCLES + 1);

  trace_state_e  state;
  logic [31:0]   last_pc;
  logic          first;
  logic [SW-1:0] stuck;

  logic          pc_change;
  logic          stuck_hit;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;
  trace_entry_t  wr_entry;
  trace_entry_t  head;

  assign pc_change = first || (PCValue != last_pc);
  assign stuck_hit = (stuck == SW'(HALT_CYCLES));

  // Disarm outranks halt detection, which in turn outranks capture.
  assign push = (state == ST_RUN) && capture_en && !stuck_hit && pc_change;
  assign pop  = rd_valid && rd_ready;
  assign drop = push && fifo_full && !pop;

  assign wr_entry = '{pc: PCValue, data: WriteData};

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_pc    = head.pc;
  assign rd_data  = head.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      last_pc <= '0;
      first   <= 1'b0;
      stuck   <= '0;
      halted  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture_en) begin
            state <= ST_RUN;
            first <= 1'b1;
            stuck <= '0;
          end
        end
        ST_RUN: begin
          if (!capture_en) begin
            state <= ST_IDLE;
            stuck <= '0;
          end else if (stuck_hit) begin
            state  <= ST_STOPPED;
            halted <= 1'b1;
            stuck  <= '0;
          end else if (pc_change) begin
            last_pc <= PCValue;
            first   <= 1'b0;
            stuck   <= '0;
          end else begin
            // stuck_hit is false here, so +1 never passes HALT_CYCLES.
            stuck <= stuck + 1'b1;
          end
        end
        ST_STOPPED: begin
          if (!capture_en) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_trace_capture.sv
module tb_pc_trace_capture;

  localparam int DEPTH = 16;
  localparam int HALT  = 8;
  localparam int DW    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCValue;
  logic [31:0] WriteData;
  logic        capture_en;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_data;
  logic [$clog2(DEPTH):0] count;
  logic        overflow;
  logic [DW-1:0] drop_count;
  logic        halted;

  always #5 clk = ~clk;

  pc_trace_capture #(
    .DEPTH      (DEPTH),
    .HALT_CYCLES(HALT),
    .DROP_W     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCValue    (PCValue),
    .WriteData  (WriteData),
    .capture_en (capture_en),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_pc      (rd_pc),
    .rd_data    (rd_data),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .halted     (halted)
  );

  // Reference model: queue of captured entries plus arming/halt bookkeeping.
  logic [31:0] q_pc[$];
  logic [31:0] q_wd[$];
  bit          m_armed, m_stopped, m_first, m_ovf;
  logic [31:0] m_last;
  int          m_same, m_drops;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [31:0] pc, input logic [31:0] wd,
                            input bit en, input bit rdy, input bit r);
    bit do_push, do_pop, was_full;
    if (!r) begin
      q_pc.delete(); q_wd.delete();
      m_armed = 0; m_stopped = 0; m_first = 0; m_ovf = 0;
      m_last = '0; m_same = 0; m_drops = 0;
      return;
    end
    do_push  = 0;
    do_pop   = rdy && (q_pc.size() != 0);
    was_full = (q_pc.size() == DEPTH);
    if (m_stopped) begin
      if (!en) m_stopped = 0;
    end else if (!m_armed) begin
      if (en) begin m_armed = 1; m_first = 1; m_same = 0; end
    end else begin
      if (!en) begin
        m_armed = 0; m_same = 0;
      end else if (m_same == HALT) begin
        m_armed = 0; m_stopped = 1; m_same = 0;
      end else if (m_first || pc != m_last) begin
        do_push = 1; m_last = pc; m_first = 0; m_same = 0;
      end else if (m_same < HALT) begin
        m_same++;
      end
    end
    if (do_pop) begin
      void'(q_pc.pop_front());
      void'(q_wd.pop_front());
    end
    if (do_push) begin
      if (was_full && !do_pop) begin
        m_ovf = 1;
        if (m_drops < (1 << DW) - 1) m_drops++;
      end else begin
        q_pc.push_back(pc);
        q_wd.push_back(wd);
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] epc, ewd;
    epc = (q_pc.size() != 0) ? q_pc[0] : 32'h0;
    ewd = (q_wd.size() != 0) ? q_wd[0] : 32'h0;
    chk("rd_valid",   32'(rd_valid),   32'(q_pc.size() != 0));
    chk("rd_pc",      rd_pc,           epc);
    chk("rd_data",    rd_data,         ewd);
    chk("count",      32'(count),      32'(q_pc.size()));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("halted",     32'(halted),     32'(m_stopped));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic [31:0] pc, input logic [31:0] wd,
                       input bit en, input bit rdy, input bit r);
    PCValue = pc; WriteData = wd; capture_en = en; rd_ready = rdy; rst = r;
    model_step(pc, wd, en, rdy, r);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc;
    int rdy_pct;
    PCValue = '0; WriteData = '0; capture_en = 0; rd_ready = 0; rst = 0;
    @(negedge clk);

    // Reset
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_valid", 32'(rd_valid), 0);

    // Basic capture
    cycle(32'h0, 32'h11, 1, 0, 1);
    cycle(32'h0, 32'h11, 1, 0, 1);
    cycle(32'h4, 32'h22, 1, 0, 1);
    cycle(32'h8, 32'h33, 1, 0, 1);
    chk("basic_count", 32'(count), 3);
    chk("basic_head_pc", rd_pc, 32'h0);
    chk("basic_head_data", rd_data, 32'h11);
    cycle(32'h8, 32'h33, 0, 1, 1);
    chk("drain1_pc", rd_pc, 32'h4);
    cycle(32'h8, 32'h33, 0, 1, 1);
    chk("drain2_pc", rd_pc, 32'h8);
    cycle(32'h8, 32'h33, 0, 1, 1);
    chk("drain_empty", 32'(rd_valid), 0);
    cycle(32'h8, 32'h33, 0, 1, 1);

    // Halt detect
    cycle(32'h20, 32'h55, 1, 0, 1);
    cycle(32'h20, 32'h55, 1, 0, 1);
    for (int i = 1; i <= HALT + 1; i++) begin
      cycle(32'h20, 32'h66, 1, 0, 1);
      if (i == HALT) chk("halt_not_yet", 32'(halted), 0);
    end
    chk("halt_rise", 32'(halted), 1);
    chk("halt_count", 32'(count), 1);
    cycle(32'h24, 32'h77, 1, 0, 1);
    chk("halt_ignores_pc", 32'(count), 1);
    cycle(32'h24, 32'h77, 0, 0, 1);
    chk("halt_clear", 32'(halted), 0);
    cycle(32'h24, 32'h77, 0, 1, 1);

    // Overflow
    cycle(32'h0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) cycle(32'h100 + 32'(i) * 4, 32'(i), 1, 0, 1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drops", 32'(drop_count), 4);
    chk("ovf_head", rd_pc, 32'h100);

    // Full with simultaneous pop (reset first to clear sticky overflow)
    cycle(0, 0, 0, 0, 0);
    cycle(32'h0, 0, 1, 0, 1);
    for (int i = 0; i < 16; i++) cycle(32'h200 + 32'(i) * 4, 32'(i), 1, 0, 1);
    chk("full_count", 32'(count), 16);
    cycle(32'h900, 32'hABCD, 1, 1, 1);
    chk("fullpop_count", 32'(count), 16);
    chk("fullpop_ovf", 32'(overflow), 0);
    for (int i = 0; i < 15; i++) cycle(32'h900, 32'hABCD, 0, 1, 1);
    chk("fullpop_tail_pc", rd_pc, 32'h900);
    chk("fullpop_tail_data", rd_data, 32'hABCD);
    cycle(32'h900, 0, 0, 1, 1);

    // Reset mid-run
    cycle(32'h0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) cycle(32'h300 + 32'(i) * 4, 32'(i), 1, 0, 1);
    cycle(32'h400, 0, 1, 0, 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_count", 32'(count), 0);
    cycle(32'h404, 32'h1, 1, 0, 1);
    chk("rst_idle_no_push", 32'(count), 0);
    cycle(32'h408, 32'h2, 1, 0, 1);
    chk("rst_resume", 32'(count), 1);

    // Disarm
    for (int i = 0; i < 5; i++) cycle(32'h500 + 32'(i) * 4, 32'(i), 0, 0, 1);
    chk("disarm_count", 32'(count), 1);
    chk("disarm_head", rd_pc, 32'h408);

    // Randomized phases with varying consumer rate
    pc = 32'h0;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: rdy_pct = 2;
        1: rdy_pct = 6;
        2: rdy_pct = 0;
        default: rdy_pct = 9;
      endcase
      for (int n = 0; n < 500; n++) begin
        if ($urandom_range(0, 2) == 0) pc = 32'($urandom_range(0, 7)) * 4;
        cycle(pc, $urandom, $urandom_range(0, 19) != 0,
              $urandom_range(0, 9) < rdy_pct, $urandom_range(0, 399) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
